sprite_plotter: RTL and testbench
=================================

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 The block SHALL use: reset resetn, synchronous, active-low; clock clk.
REQ-002 Ports, in order:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
obj_sel  in  4  object select from draw sequencer (0 player, 1-4 enemy1-4, 5 bullet)
enable  in  1  scan advance permit; low freezes scan
player_x/player_y  in  8/7  player top-left pixel
enemy_x[0..3]/enemy_y[0..3]  in  8/7 each  enemy top-left pixels
enemy_alive  in  4  per-enemy live flag
bullet_x/bullet_y  in  8/7  bullet top-left pixel
bullet_active  in  1  bullet live flag
x  out  8  pixel column to VGA adapter
y  out  7  pixel row to VGA adapter
colour  out  3  pixel colour
plot  out  1  pixel write strobe
done  out  1  one-cycle object-complete pulse to draw sequencer

Function
REQ-003 FSM states SHALL be LATCH, PLOT and DONE.
REQ-004 LATCH (1 cycle): capture obj_sel, the selected object's position, size, colour and live flag; clear scan offsets; go to PLOT, or straight to DONE for obj_sel > 5.
REQ-005 Sizes: player 8x8, enemy 8x8, bullet 2x4 (WxH).
REQ-006 Colours: player 3'b010, enemy 3'b100, bullet 3'b111; a dead enemy or inactive bullet SHALL be drawn as 3'b000 (erase).
REQ-007 PLOT: each cycle with enable=1, x = base_x + dx, y = base_y + dy; dx increments, wrapping to 0 at W-1 and incrementing dy; exit to DONE after the (W-1, H-1) pixel.
REQ-008 enable=0 in PLOT SHALL hold dx/dy and force plot=0.
REQ-009 plot SHALL be 1 only in PLOT with enable=1 and the pixel on screen (x < 160, y < 120); off-screen pixels advance the scan with plot=0. Sums use 9-bit/8-bit width so no wrap occurs.
REQ-010 DONE (1 cycle): done=1, plot=0; next state LATCH, which samples the sequencer's updated obj_sel.
REQ-011 Latency: a valid object takes W*H+2 cycles from LATCH to next LATCH (player 66, bullet 10); an invalid select takes 2.
REQ-012 Positions SHALL be sampled only in LATCH; input changes during PLOT do not affect the current sprite.
REQ-013 x, y, colour SHALL be registered; plot and done SHALL be registered to align with x/y.

Reset
REQ-014 resetn=0 at a clock edge SHALL force state LATCH, dx=dy=0, x=0, y=0, colour=0, plot=0, done=0, aborting any scan in progress.
REQ-015 The first LATCH after reset release SHALL sample obj_sel normally (expected 0).

Structure
REQ-016 A shared package SHALL hold object IDs 0-5, per-object width/height, per-object colours, the erase colour, and screen bounds 160/120.
REQ-017 The dx/dy scan SHALL be a sub-module pixel_scan_counter (parameterless, width/height inputs, enable, clear, last-pixel flag).
REQ-018 The combined draw sequencer + sprite_plotter loop SHALL cycle objects 0-5 indefinitely without stalls.

Verification
REQ-019 Reset, obj_sel=0, player at (10,20), enable=1 -> 64 plot pulses covering x 10-17, y 20-27, colour 010, done at cycle 66.
REQ-020 obj_sel=5, bullet at (158,118), bullet_active=1 -> 8 scan cycles, plot=1 only for (158,118),(159,118),(158,119),(159,119); colour 111; done follows.
REQ-021 obj_sel=2, enemy_alive[1]=0, enemy1 at (40,5) -> 64 plots at x 40-47, y 5-12, colour 000.
REQ-022 enable held low for 5 cycles mid-player scan -> plot=0 and x/y frozen for 5 cycles, total latency 71 cycles, no pixel skipped or repeated.
REQ-023 obj_sel=9 -> no plot, done after 2 cycles; resetn=0 mid-enemy scan -> next cycle plot=0, done=0, state LATCH.
REQ-024 Closed loop with draw sequencer -> done observed 6 times per frame, obj_sel sequence 0,1,2,3,4,5,0.

Source files
------------

// File: rtl/sprite_plotter_pkg.sv
// Shared object IDs, sprite geometry, colours and screen bounds for the sprite plotter.
package sprite_plotter_pkg;

  typedef enum logic [3:0] {
    OBJ_PLAYER = 4'd0,
    OBJ_ENEMY1 = 4'd1,
    OBJ_ENEMY2 = 4'd2,
    OBJ_ENEMY3 = 4'd3,
    OBJ_ENEMY4 = 4'd4,
    OBJ_BULLET = 4'd5
  } obj_id_t;

  typedef enum logic [1:0] {
    ST_LATCH,
    ST_PLOT,
    ST_DONE
  } plot_state_t;

  localparam logic [3:0] PLAYER_W = 4'd8;
  localparam logic [3:0] PLAYER_H = 4'd8;
  localparam logic [3:0] ENEMY_W  = 4'd8;
  localparam logic [3:0] ENEMY_H  = 4'd8;
  localparam logic [3:0] BULLET_W = 4'd2;
  localparam logic [3:0] BULLET_H = 4'd4;

  localparam logic [2:0] PLAYER_COLOUR = 3'b010;
  localparam logic [2:0] ENEMY_COLOUR  = 3'b100;
  localparam logic [2:0] BULLET_COLOUR = 3'b111;
  localparam logic [2:0] ERASE_COLOUR  = 3'b000;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

endpackage

// File: rtl/sprite_plotter_scan.sv
// Raster scan of a W x H sprite: dx runs fastest, dy advances when dx wraps.
module pixel_scan_counter
  import sprite_plotter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] i_width,
  input  logic [3:0] i_height,
  input  logic       i_enable,
  input  logic       i_clear,
  output logic [2:0] o_dx,
  output logic [2:0] o_dy,
  output logic       o_last
);

  logic [2:0] r_dx;
  logic [2:0] r_dy;
  logic       w_row_end;
  logic       w_col_end;

  // End-of-row / end-of-column detection for the current offsets.
  always_comb begin
    w_row_end = ({1'b0, r_dx} == (i_width  - 4'd1));
    w_col_end = ({1'b0, r_dy} == (i_height - 4'd1));
  end

  // Offset registers: cleared on reset or clear, advanced only while enabled.
  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_enable) begin
      if (w_row_end) begin
        r_dx <= '0;
        r_dy <= w_col_end ? 3'd0 : r_dy + 3'd1;
      end else begin
        r_dx <= r_dx + 3'd1;
      end
    end
  end

  assign o_dx   = r_dx;
  assign o_dy   = r_dy;
  assign o_last = w_row_end && w_col_end;

endmodule

// File: rtl/sprite_plotter.sv
// Draws one selected sprite per LATCH/PLOT/DONE pass, emitting registered VGA pixel writes.
module sprite_plotter
  import sprite_plotter_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] obj_sel,
  input  logic       enable,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  input  logic [7:0] enemy_x [0:3],
  input  logic [6:0] enemy_y [0:3],
  input  logic [3:0] enemy_alive,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  plot_state_t r_state, w_next;

  logic [7:0] r_base_x;
  logic [6:0] r_base_y;
  logic [3:0] r_w, r_h;
  logic [2:0] r_obj_colour;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot, r_done;

  logic [7:0] w_ld_x;
  logic [6:0] w_ld_y;
  logic [3:0] w_ld_w, w_ld_h;
  logic [2:0] w_ld_colour;
  logic [1:0] w_enemy_idx;

  logic       w_scan_clear, w_scan_en;
  logic [2:0] w_dx, w_dy;
  logic       w_last;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;

  pixel_scan_counter u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .i_width  (r_w),
    .i_height (r_h),
    .i_enable (w_scan_en),
    .i_clear  (w_scan_clear),
    .o_dx     (w_dx),
    .o_dy     (w_dy),
    .o_last   (w_last)
  );

  // Select position, size and colour of the object named by obj_sel.
  always_comb begin
    w_enemy_idx = obj_sel[1:0] - 2'd1;
    w_ld_x      = player_x;
    w_ld_y      = player_y;
    w_ld_w      = PLAYER_W;
    w_ld_h      = PLAYER_H;
    w_ld_colour = PLAYER_COLOUR;
    case (obj_sel)
      OBJ_ENEMY1, OBJ_ENEMY2, OBJ_ENEMY3, OBJ_ENEMY4: begin
        w_ld_x      = enemy_x[w_enemy_idx];
        w_ld_y      = enemy_y[w_enemy_idx];
        w_ld_w      = ENEMY_W;
        w_ld_h      = ENEMY_H;
        w_ld_colour = enemy_alive[w_enemy_idx] ? ENEMY_COLOUR : ERASE_COLOUR;
      end
      OBJ_BULLET: begin
        w_ld_x      = bullet_x;
        w_ld_y      = bullet_y;
        w_ld_w      = BULLET_W;
        w_ld_h      = BULLET_H;
        w_ld_colour = bullet_active ? BULLET_COLOUR : ERASE_COLOUR;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_LATCH;
    else         r_state <= w_next;
  end

  // Next-state logic and scan-counter control.
  always_comb begin
    w_next       = r_state;
    w_scan_clear = 1'b0;
    w_scan_en    = 1'b0;
    case (r_state)
      ST_LATCH: begin
        w_scan_clear = 1'b1;
        w_next       = (obj_sel > OBJ_BULLET) ? ST_DONE : ST_PLOT;
      end
      ST_PLOT: begin
        w_scan_en = enable;
        if (enable && w_last) w_next = ST_DONE;
      end
      ST_DONE:  w_next = ST_LATCH;
      default:  w_next = ST_LATCH;
    endcase
  end

  // Object attributes are captured only in LATCH so mid-scan input changes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_obj_colour <= '0;
    end else if (r_state == ST_LATCH) begin
      r_base_x     <= w_ld_x;
      r_base_y     <= w_ld_y;
      r_w          <= w_ld_w;
      r_h          <= w_ld_h;
      r_obj_colour <= w_ld_colour;
    end
  end

  // Widened sums so off-screen coordinates cannot wrap back on screen.
  always_comb begin
    w_sum_x = {1'b0, r_base_x} + {6'b0, w_dx};
    w_sum_y = {1'b0, r_base_y} + {5'b0, w_dy};
  end

  // Registered pixel outputs; plot/done share the one-cycle lag of x/y.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      r_done <= (r_state == ST_DONE);
      if (r_state == ST_PLOT && enable) begin
        r_x      <= w_sum_x[7:0];
        r_y      <= w_sum_y[6:0];
        r_colour <= r_obj_colour;
        r_plot   <= (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));
      end
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign done   = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed self-checking bench for sprite_plotter.
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] obj_sel_d;
  logic [3:0] seq_sel;
  logic [3:0] seq_next;
  logic [3:0] dut_sel;
  logic       loop_mode;
  logic       enable;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] enemy_x [4];
  logic [6:0] enemy_y [4];
  logic [3:0] enemy_alive;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic       bullet_active;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Draw-sequencer model: advance the object on done so LATCH sees the next ID.
  assign seq_next = (seq_sel == 4'd5) ? 4'd0 : seq_sel + 4'd1;
  assign dut_sel  = loop_mode ? (done ? seq_next : seq_sel) : obj_sel_d;

  always @(posedge clk) begin
    if (!resetn)               seq_sel <= 4'd0;
    else if (loop_mode && done) seq_sel <= seq_next;
  end

  sprite_plotter dut (
    .clk           (clk),
    .resetn        (resetn),
    .obj_sel       (dut_sel),
    .enable        (enable),
    .player_x      (player_x),
    .player_y      (player_y),
    .enemy_x       (enemy_x),
    .enemy_y       (enemy_y),
    .enemy_alive   (enemy_alive),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .done          (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " plot"},   32'(plot),   32'd0);
    check({tag, " done"},   32'(done),   32'd0);
    check({tag, " x"},      32'(x),      32'd0);
    check({tag, " y"},      32'(y),      32'd0);
    check({tag, " colour"}, 32'(colour), 32'd0);
  endtask

  task automatic do_reset(input logic loop);
    @(negedge clk);
    resetn    = 1'b0;
    loop_mode = loop;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
  endtask

  // Draws one object from a LATCH edge, checking every scan cycle against a raster model.
  task automatic run_obj(input string tag, input logic [3:0] sel, input int bx, input int by,
                         input int w, input int h, input logic [2:0] col,
                         input int hold_at, input int hold_len,
                         input int exp_plots, input int exp_done_cycle);
    int s, nplot, done_edge, ex, ey;
    logic [7:0] last_x;
    logic [6:0] last_y;
    logic en_edge, on;
    obj_sel_d = sel;
    enable    = 1'b1;
    s = 0; nplot = 0; done_edge = -1;
    last_x = '0; last_y = '0;
    for (int e = 0; e < 400 && done_edge < 0; e++) begin
      en_edge = enable;
      @(posedge clk);
      @(negedge clk);
      if (e == 20) begin
        player_x = 8'd0; player_y = 7'd0;
        bullet_x = 8'd0; bullet_y = 7'd0;
        for (int i = 0; i < 4; i++) begin enemy_x[i] = 8'd0; enemy_y[i] = 7'd0; end
      end
      if (plot) nplot++;
      if (e == 0) begin
        check({tag, " latch plot"}, 32'(plot), 32'd0);
        check({tag, " latch done"}, 32'(done), 32'd0);
      end else if (s < w * h) begin
        if (en_edge) begin
          ex = bx + s % w;
          ey = by + s / w;
          on = (ex < 160) && (ey < 120);
          check({tag, " plot"}, 32'(plot), 32'(on));
          if (on) begin
            check({tag, " x"},      32'(x),      32'(ex));
            check({tag, " y"},      32'(y),      32'(ey));
            check({tag, " colour"}, 32'(colour), 32'(col));
          end
          last_x = ex[7:0];
          last_y = ey[6:0];
          s++;
        end else begin
          check({tag, " hold plot"}, 32'(plot), 32'd0);
          check({tag, " hold x"},    32'(x),    32'(last_x));
          check({tag, " hold y"},    32'(y),    32'(last_y));
        end
        check({tag, " early done"}, 32'(done), 32'd0);
      end else begin
        check({tag, " done"},      32'(done), 32'd1);
        check({tag, " done plot"}, 32'(plot), 32'd0);
        done_edge = e;
      end
      enable = !((e + 1 >= hold_at) && (e + 1 < hold_at + hold_len));
    end
    enable = 1'b1;
    check({tag, " plot count"},   32'(nplot),         32'(exp_plots));
    check({tag, " done latency"}, 32'(done_edge + 1), 32'(exp_done_cycle));
  endtask

  task automatic set_positions();
    player_x = 8'd10;  player_y = 7'd20;
    enemy_x[0] = 8'd30;  enemy_y[0] = 7'd5;
    enemy_x[1] = 8'd40;  enemy_y[1] = 7'd5;
    enemy_x[2] = 8'd50;  enemy_y[2] = 7'd60;
    enemy_x[3] = 8'd100; enemy_y[3] = 7'd60;
    bullet_x = 8'd158; bullet_y = 7'd118;
  endtask

  int exp_seq [7] = '{0, 1, 2, 3, 4, 5, 0};
  int rec_sel [7];
  int rec_cyc [7];
  int ndone;

  initial begin
    resetn        = 1'b0;
    loop_mode     = 1'b0;
    enable        = 1'b1;
    obj_sel_d     = 4'd0;
    enemy_alive   = 4'b1101;
    bullet_active = 1'b1;
    set_positions();

    // Player scan with reset checks first.
    do_reset(1'b0);
    run_obj("player", 4'd0, 10, 20, 8, 8, 3'b010, 1000, 0, 64, 66);

    // Bullet at the bottom-right corner: half of its scan is off screen.
    set_positions();
    run_obj("bullet", 4'd5, 158, 118, 2, 4, 3'b111, 1000, 0, 4, 10);

    // Dead enemy at index 1 is erased.
    set_positions();
    run_obj("dead enemy", 4'd2, 40, 5, 8, 8, 3'b000, 1000, 0, 64, 66);

    // Live enemy at index 3.
    set_positions();
    run_obj("enemy4", 4'd4, 100, 60, 8, 8, 3'b100, 1000, 0, 64, 66);

    // Player with enable low for five cycles mid-scan.
    set_positions();
    run_obj("player hold", 4'd0, 10, 20, 8, 8, 3'b010, 30, 5, 64, 71);

    // Invalid select.
    set_positions();
    run_obj("invalid", 4'd9, 0, 0, 0, 0, 3'b000, 1000, 0, 0, 2);

    // Reset in the middle of an enemy scan.
    set_positions();
    obj_sel_d = 4'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid reset");
    resetn = 1'b1;
    run_obj("after reset", 4'd0, 10, 20, 8, 8, 3'b010, 1000, 0, 64, 66);

    // Closed loop with the draw-sequencer model.
    set_positions();
    do_reset(1'b1);
    ndone = 0;
    for (int cyc = 0; cyc < 1000 && ndone < 7; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        rec_sel[ndone] = int'(seq_sel);
        rec_cyc[ndone] = cyc;
        ndone++;
      end
    end
    check("loop done count", 32'(ndone), 32'd7);
    if (ndone == 7) begin
      for (int i = 0; i < 7; i++) check("loop obj_sel order", 32'(rec_sel[i]), 32'(exp_seq[i]));
      check("loop first done", 32'(rec_cyc[0]), 32'd65);
      check("loop frame cycles", 32'(rec_cyc[6] - rec_cyc[0]), 32'd340);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
